// File: rtl/dma_activity_monitor.sv
// DMA activity monitor: tracks transfers on the beat handshake, drives the rdy / dma_in_use
// status levels and keeps beat/transfer counters plus sticky error flags.
module dma_activity_monitor #(
  parameter int LEN_W       = 16,
  parameter int INIT_CYCLES = 1024,
  parameter int HOLD_CYCLES = 64,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dma_start,
  input  logic [LEN_W-1:0] dma_len,
  input  logic             dma_valid,
  input  logic             dma_ready,
  input  logic             dma_abort,
  input  logic             err_clr,
  output logic             rdy,
  output logic             dma_in_use,
  output logic [LEN_W-1:0] word_count,
  output logic [15:0]      xfer_count,
  output logic             err_overlap,
  output logic             err_stray,
  output logic             err_timeout
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t             state;
  logic [INIT_W-1:0]  init_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [LEN_W-1:0]   len_reg;

  logic beat, in_active, last_beat, tmo_hit, finish;
  logic set_overlap, set_stray, set_timeout;

  assign beat        = dma_valid & dma_ready;
  assign in_active   = (state == ACTIVE);
  assign last_beat   = (word_count + LEN_W'(1)) == len_reg;
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  // Abort takes priority over a same-cycle beat, so that beat is neither counted nor completing.
  assign finish      = dma_abort | (beat ? last_beat : tmo_hit);
  assign set_overlap = in_active & dma_start;
  assign set_stray   = ~in_active & beat;
  assign set_timeout = in_active & ~dma_abort & ~beat & tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
      rdy      <= 1'b0;
    end else if (!rdy) begin
      if (init_cnt == INIT_LAST) rdy <= 1'b1;
      else                       init_cnt <= init_cnt + INIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_reg    <= '0;
      word_count <= '0;
      xfer_count <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      dma_in_use <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (dma_start) begin
            len_reg    <= dma_len;
            word_count <= '0;
            tmo_cnt    <= '0;
            dma_in_use <= 1'b1;
            if (dma_len == '0) begin
              state      <= HOLD;
              hold_cnt   <= HOLD_LAST;
              xfer_count <= xfer_count + 16'd1;
            end else begin
              state <= ACTIVE;
            end
          end else if (state == HOLD) begin
            if (hold_cnt == '0) begin
              state      <= IDLE;
              dma_in_use <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (!dma_abort) begin
            if (beat) begin
              tmo_cnt <= '0;
              if (word_count != '1) word_count <= word_count + LEN_W'(1);
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          if (finish) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_LAST;
            xfer_count <= xfer_count + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          dma_in_use <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overlap <= 1'b0;
      err_stray   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_overlap <= set_overlap | (err_overlap & ~err_clr);
      err_stray   <= set_stray   | (err_stray   & ~err_clr);
      err_timeout <= set_timeout | (err_timeout & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dma_activity_monitor.sv
// Directed self-checking bench for dma_activity_monitor with small timing parameters.
module tb_dma_activity_monitor;

  localparam int LEN_W = 16;
  localparam int INIT  = 10;
  localparam int HOLD  = 4;
  localparam int TMO   = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             dma_start = 1'b0;
  logic [LEN_W-1:0] dma_len = '0;
  logic             dma_valid = 1'b0;
  logic             dma_ready = 1'b0;
  logic             dma_abort = 1'b0;
  logic             err_clr = 1'b0;
  logic             rdy, dma_in_use, err_overlap, err_stray, err_timeout;
  logic [LEN_W-1:0] word_count;
  logic [15:0]      xfer_count;

  int checks = 0;
  int failures = 0;

  dma_activity_monitor #(
    .LEN_W(LEN_W), .INIT_CYCLES(INIT), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .dma_start(dma_start), .dma_len(dma_len),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_abort(dma_abort),
    .err_clr(err_clr), .rdy(rdy), .dma_in_use(dma_in_use),
    .word_count(word_count), .xfer_count(xfer_count),
    .err_overlap(err_overlap), .err_stray(err_stray), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable values from that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({rdy, dma_in_use, err_overlap, err_stray, err_timeout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=00000",
               {rdy, dma_in_use, err_overlap, err_stray, err_timeout});
    end
    checks++;
    if (word_count !== 16'd0 || xfer_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts got wc=%0d xc=%0d expected 0 0", word_count, xfer_count);
    end
  endtask

  task automatic test_rdy();
    for (int k = 1; k <= INIT + 3; k++) begin
      step();
      checks++;
      if (rdy !== (k >= INIT)) begin
        failures++;
        $display("FAIL rdy_cycle_%0d got=%b expected=%b", k, rdy, (k >= INIT));
      end
    end
    $display("rdy sequence checked over %0d cycles", INIT + 3);
  endtask

  task automatic test_normal();
    dma_start = 1'b1; dma_len = 16'd4;
    step();
    dma_start = 1'b0;
    checks++;
    if (dma_in_use !== 1'b1 || word_count !== 16'd0) begin
      failures++;
      $display("FAIL normal_start got in_use=%b wc=%0d expected 1 0", dma_in_use, word_count);
    end
    for (int i = 0; i < 4; i++) begin
      dma_valid = 1'b1; dma_ready = 1'b0;  // valid without ready is not a beat
      step();
      dma_ready = 1'b1;
      step();
      dma_valid = 1'b0; dma_ready = 1'b0;
      checks++;
      if (word_count !== 16'(i + 1)) begin
        failures++;
        $display("FAIL normal_beat%0d got wc=%0d expected=%0d", i, word_count, i + 1);
      end
      if (i < 3) step();
    end
    checks++;
    if (xfer_count !== 16'd1 || dma_in_use !== 1'b1) begin
      failures++;
      $display("FAIL normal_done got xc=%0d in_use=%b expected 1 1", xfer_count, dma_in_use);
    end
    for (int j = 1; j <= HOLD; j++) begin
      step();
      checks++;
      if (dma_in_use !== (j < HOLD)) begin
        failures++;
        $display("FAIL normal_hold%0d got in_use=%b expected=%b", j, dma_in_use, (j < HOLD));
      end
    end
    checks++;
    if ({err_overlap, err_stray, err_timeout} !== 3'b000 || word_count !== 16'd4) begin
      failures++;
      $display("FAIL normal_final got errs=%b wc=%0d expected 000 4",
               {err_overlap, err_stray, err_timeout}, word_count);
    end
    $display("xfer len=4 wc=%0d xc=%0d", word_count, xfer_count);
  endtask

  task automatic test_zero_len();
    dma_start = 1'b1; dma_len = 16'd0;
    step();
    dma_start = 1'b0;
    checks++;
    if (dma_in_use !== 1'b1 || word_count !== 16'd0 || xfer_count !== 16'd2) begin
      failures++;
      $display("FAIL zero_start got in_use=%b wc=%0d xc=%0d expected 1 0 2",
               dma_in_use, word_count, xfer_count);
    end
    for (int j = 1; j <= HOLD; j++) begin
      step();
      checks++;
      if (dma_in_use !== (j < HOLD)) begin
        failures++;
        $display("FAIL zero_hold%0d got in_use=%b expected=%b", j, dma_in_use, (j < HOLD));
      end
    end
    $display("xfer len=0 wc=%0d xc=%0d", word_count, xfer_count);
  endtask

  task automatic test_timeout();
    dma_start = 1'b1; dma_len = 16'd8;
    step();
    dma_start = 1'b0;
    dma_valid = 1'b1; dma_ready = 1'b1;
    repeat (3) step();
    dma_valid = 1'b0; dma_ready = 1'b0;
    repeat (TMO - 1) step();
    checks++;
    if (err_timeout !== 1'b0 || dma_in_use !== 1'b1 || xfer_count !== 16'd2) begin
      failures++;
      $display("FAIL tmo_before got err=%b in_use=%b xc=%0d expected 0 1 2",
               err_timeout, dma_in_use, xfer_count);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || word_count !== 16'd3 || xfer_count !== 16'd3) begin
      failures++;
      $display("FAIL tmo_hit got err=%b wc=%0d xc=%0d expected 1 3 3",
               err_timeout, word_count, xfer_count);
    end
    repeat (HOLD) step();
    checks++;
    if (dma_in_use !== 1'b0) begin
      failures++;
      $display("FAIL tmo_idle got in_use=%b expected=0", dma_in_use);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clr got err=%b expected=0", err_timeout);
    end
    $display("xfer len=8 timeout wc=%0d xc=%0d", word_count, xfer_count);
  endtask

  task automatic test_errors();
    dma_valid = 1'b1; dma_ready = 1'b1;
    step();
    dma_valid = 1'b0; dma_ready = 1'b0;
    checks++;
    if (err_stray !== 1'b1 || err_overlap !== 1'b0 || word_count !== 16'd3) begin
      failures++;
      $display("FAIL stray got stray=%b ovl=%b wc=%0d expected 1 0 3",
               err_stray, err_overlap, word_count);
    end
    dma_start = 1'b1; dma_len = 16'd2;
    step();
    dma_len = 16'd7;  // second start in ACTIVE must not relatch length
    step();
    dma_start = 1'b0;
    checks++;
    if (err_overlap !== 1'b1) begin
      failures++;
      $display("FAIL overlap got=%b expected=1", err_overlap);
    end
    dma_valid = 1'b1; dma_ready = 1'b1;
    repeat (2) step();
    dma_valid = 1'b0; dma_ready = 1'b0;
    checks++;
    if (word_count !== 16'd2 || xfer_count !== 16'd4) begin
      failures++;
      $display("FAIL overlap_len got wc=%0d xc=%0d expected 2 4", word_count, xfer_count);
    end
    repeat (HOLD) step();
    err_clr = 1'b1; dma_valid = 1'b1; dma_ready = 1'b1;
    step();
    dma_valid = 1'b0; dma_ready = 1'b0;
    checks++;
    if (err_stray !== 1'b1 || err_overlap !== 1'b0) begin
      failures++;
      $display("FAIL clr_set_wins got stray=%b ovl=%b expected 1 0", err_stray, err_overlap);
    end
    step();
    err_clr = 1'b0;
    checks++;
    if (err_stray !== 1'b0 || err_overlap !== 1'b0) begin
      failures++;
      $display("FAIL clr got stray=%b ovl=%b expected 0 0", err_stray, err_overlap);
    end
    $display("xfer len=2 overlap wc=%0d xc=%0d", word_count, xfer_count);
  endtask

  task automatic test_abort_retrigger();
    dma_start = 1'b1; dma_len = 16'd5;
    step();
    dma_start = 1'b0;
    dma_valid = 1'b1; dma_ready = 1'b1;
    repeat (2) step();
    dma_abort = 1'b1;
    step();
    dma_abort = 1'b0; dma_valid = 1'b0; dma_ready = 1'b0;
    checks++;
    if (word_count !== 16'd2 || xfer_count !== 16'd5 || dma_in_use !== 1'b1) begin
      failures++;
      $display("FAIL abort got wc=%0d xc=%0d in_use=%b expected 2 5 1",
               word_count, xfer_count, dma_in_use);
    end
    step();
    dma_start = 1'b1; dma_len = 16'd1;
    step();
    dma_start = 1'b0;
    checks++;
    if (dma_in_use !== 1'b1 || word_count !== 16'd0) begin
      failures++;
      $display("FAIL retrigger got in_use=%b wc=%0d expected 1 0", dma_in_use, word_count);
    end
    step();
    checks++;
    if (dma_in_use !== 1'b1 || xfer_count !== 16'd5) begin
      failures++;
      $display("FAIL retrig_active got in_use=%b xc=%0d expected 1 5", dma_in_use, xfer_count);
    end
    dma_valid = 1'b1; dma_ready = 1'b1;
    step();
    dma_valid = 1'b0; dma_ready = 1'b0;
    checks++;
    if (word_count !== 16'd1 || xfer_count !== 16'd6 || err_stray !== 1'b0) begin
      failures++;
      $display("FAIL retrig_done got wc=%0d xc=%0d stray=%b expected 1 6 0",
               word_count, xfer_count, err_stray);
    end
    for (int j = 1; j <= HOLD; j++) begin
      step();
      checks++;
      if (dma_in_use !== (j < HOLD)) begin
        failures++;
        $display("FAIL retrig_hold%0d got in_use=%b expected=%b", j, dma_in_use, (j < HOLD));
      end
    end
    $display("xfer len=5 abort + len=1 retrigger wc=%0d xc=%0d", word_count, xfer_count);
  endtask

  task automatic test_reset_mid();
    dma_start = 1'b1; dma_len = 16'd3;
    step();
    dma_start = 1'b0;
    dma_valid = 1'b1; dma_ready = 1'b1;
    step();
    dma_valid = 1'b0; dma_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (word_count !== 16'd0 || xfer_count !== 16'd0 || dma_in_use !== 1'b0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got wc=%0d xc=%0d in_use=%b rdy=%b expected 0 0 0 0",
               word_count, xfer_count, dma_in_use, rdy);
    end
    step();
    checks++;
    if (dma_in_use !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle got in_use=%b expected=0", dma_in_use);
    end
    $display("reset mid-transfer wc=%0d xc=%0d", word_count, xfer_count);
  endtask

  initial begin
    test_reset();
    test_rdy();
    test_normal();
    test_zero_len();
    test_timeout();
    test_errors();
    test_abort_retrigger();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
